// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch controller.
package fetch_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StFetch,
    StValid,
    StDrain
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0004;

endpackage

// File: rtl/fetch_pc_reg.sv
// 32-bit program counter with synchronous active-high reset and load enable.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc <= RESET_VECTOR;
    end else if (i_load) begin
      r_pc <= i_d;
    end
  end

  assign o_q = r_pc;

endmodule

// File: rtl/fetch_ctrl_rv32i.sv
// RV32I instruction fetch controller: one outstanding imem request, redirect drain.
// Optional feature macro FETCH_MISALIGN_TRAP_EN: misaligned redirects trap to TRAP_VECTOR.
module fetch_ctrl_rv32i
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] TRAP_VECTOR  = DEF_TRAP_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
`ifdef FETCH_MISALIGN_TRAP_EN
  output logic        misalign_exc,
`endif
  output logic [31:0] pc_out
);

`ifdef FETCH_MISALIGN_TRAP_EN
  localparam bit MisalignEn = 1'b1;
`else
  localparam bit MisalignEn = 1'b0;
`endif

  fetch_state_e r_state;
  logic         r_inst_valid;
  logic [31:0]  r_inst_out;
  logic [31:0]  r_inst_pc;
  logic [31:0]  r_drain_addr;

  logic         w_misaligned;
  logic [31:0]  w_target;
  logic [31:0]  w_pc;
  logic         w_pc_load;
  logic [31:0]  w_pc_d;

  assign w_misaligned = (redirect_target[1:0] != 2'b00);
  // Without the trap, the low bits are simply dropped.
  assign w_target = (MisalignEn && w_misaligned) ? TRAP_VECTOR
                                                 : {redirect_target[31:2], 2'b00};

  always_comb begin
    w_pc_load = 1'b0;
    w_pc_d    = w_pc;
    if (redirect_valid) begin
      w_pc_load = 1'b1;
      w_pc_d    = w_target;
    end else if (r_state == StFetch && imem_ack) begin
      w_pc_load = 1'b1;
      w_pc_d    = w_pc + PC_INC;
    end
  end

  fetch_pc_reg #(
    .RESET_VECTOR(RESET_VECTOR)
  ) u_pc_reg (
    .clock (clock),
    .reset (reset),
    .i_load(w_pc_load),
    .i_d   (w_pc_d),
    .o_q   (w_pc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= StBoot;
      r_inst_valid <= 1'b0;
      r_inst_out   <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_drain_addr <= RESET_VECTOR;
    end else begin
      case (r_state)
        StBoot: r_state <= StFetch;
        StFetch: begin
          if (redirect_valid) begin
            // Request still in flight: remember its address until the ack arrives.
            if (!imem_ack) begin
              r_drain_addr <= w_pc;
              r_state      <= StDrain;
            end
          end else if (imem_ack) begin
            r_inst_out   <= imem_rdata;
            r_inst_pc    <= w_pc;
            r_inst_valid <= 1'b1;
            r_state      <= StValid;
          end
        end
        StValid: begin
          if (redirect_valid || (inst_ready && !stall)) begin
            r_inst_valid <= 1'b0;
            r_state      <= StFetch;
          end
        end
        StDrain: begin
          if (imem_ack) r_state <= StFetch;
        end
        default: r_state <= StBoot;
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic r_misalign;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= redirect_valid && w_misaligned;
    end
  end

  assign misalign_exc = r_misalign;
`endif

  assign imem_req   = (r_state == StFetch) || (r_state == StDrain);
  assign imem_addr  = (r_state == StDrain) ? r_drain_addr : w_pc;
  assign inst_valid = r_inst_valid;
  assign inst_out   = r_inst_out;
  assign inst_pc    = r_inst_pc;
  assign pc_out     = w_pc;

endmodule

// File: doc/fetch_ctrl_rv32i.md
FETCH_CTRL_RV32I -- requirements
Module: fetch_ctrl_rv32i

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter TRAP_VECTOR, default 32'h0000_0004, redirect address on a misaligned target (when the misaligned-target feature is compiled in).
REQ-003 Port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, synchronous, active-high.
REQ-005 Port stall, input, 1, hazard hold from decode; blocks consumption of the held instruction.
REQ-006 Port redirect_valid, input, 1, branch/jump taken this cycle.
REQ-007 Port redirect_target, input, 32, new PC when redirect_valid=1.
REQ-008 Port imem_req, output, 1, instruction memory request.
REQ-009 Port imem_addr, output, 32, fetch address.
REQ-010 Port imem_ack, input, 1, memory response valid.
REQ-011 Port imem_rdata, input, 32, instruction word, valid with imem_ack.
REQ-012 Port inst_valid, output, 1, inst_out/inst_pc hold a valid instruction.
REQ-013 Port inst_out, output, 32, fetched instruction.
REQ-014 Port inst_pc, output, 32, address of inst_out.
REQ-015 Port inst_ready, input, 1, decode accepts the instruction.
REQ-016 Port pc_out, output, 32, next address to fetch.
REQ-017 Port misalign_exc, output, 1, one-cycle pulse on a misaligned redirect; present only with FETCH_MISALIGN_TRAP_EN.

Function
REQ-018 The FSM SHALL have four states: BOOT, FETCH, VALID, DRAIN.
REQ-019 BOOT SHALL go to FETCH unconditionally after one cycle, with imem_req=0.
REQ-020 In FETCH, imem_req=1 and imem_addr=pc; on imem_ack with no redirect: latch inst_out=imem_rdata, inst_pc=pc; pc<=pc+4; go to VALID.
REQ-021 In VALID, inst_valid=1 and imem_req=0; on inst_ready=1 and stall=0, the instruction is consumed and the FSM goes to FETCH; otherwise inst_out and inst_pc hold.
REQ-022 imem_addr SHALL stay stable while imem_req=1 and imem_ack=0, including in DRAIN, which uses a saved in-flight address.
REQ-023 Redirect in FETCH with imem_ack=1: discard the response, pc<=target, stay in FETCH.
REQ-024 Redirect in FETCH with imem_ack=0: pc<=target, go to DRAIN.
REQ-025 In DRAIN, imem_req=1 at the saved address; on ack, discard the data and go to FETCH; a further redirect updates pc and stays in DRAIN (latest target wins).
REQ-026 Redirect in VALID: inst_valid<=0 next cycle, pc<=target, go to FETCH; redirect takes priority over consumption.
REQ-027 Redirect in BOOT: pc<=target, go to FETCH.
REQ-028 PC arithmetic SHALL be modulo 2^32, so 32'hFFFF_FFFC+4 = 32'h0000_0000.
REQ-029 Latency: imem_ack in FETCH gives inst_valid=1 on the next cycle.
REQ-030 At most one memory request SHALL be outstanding; stall SHALL never drop an asserted imem_req.

Reset
REQ-031 With reset=1 at a clock edge: state=BOOT, pc_out=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, inst_valid=0, inst_out=0, inst_pc=0, misalign_exc=0.
REQ-032 Reset SHALL override all inputs in every state, including mid-DRAIN; any pending ack is ignored.

Configuration
REQ-033 With FETCH_MISALIGN_TRAP_EN defined: a redirect_target with [1:0]!=2'b00 SHALL load pc<=TRAP_VECTOR and pulse misalign_exc for exactly one cycle; the state transition follows REQ-023..027.
REQ-034 Without FETCH_MISALIGN_TRAP_EN: the port misalign_exc is absent, and pc<={redirect_target[31:2],2'b00}.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum, the PC_INC=4 constant and the default vector constants.
REQ-036 Sub-module fetch_pc_reg SHALL implement the 32-bit PC register with synchronous active-high reset to RESET_VECTOR and a load enable.

Verification
REQ-037 Reset, then ack every cycle with inst_ready=1 -> imem_addr sequence 0x0, 0x4, 0x8; inst_pc matches each fetched address.
REQ-038 Hold inst_ready=0 or stall=1 for 3 cycles in VALID -> inst_out/inst_pc stable; imem_req=0; no pc change.
REQ-039 Redirect to 0x100 in FETCH while ack is delayed 2 cycles -> DRAIN holds the old imem_addr; data discarded; next request at 0x100; no inst_valid for the old address.
REQ-040 Redirect to 0x200 in VALID with inst_ready=1 the same cycle -> instruction dropped; next imem_addr=0x200.
REQ-041 Redirect to 0x102 -> with FETCH_MISALIGN_TRAP_EN: next fetch at 0x4 and misalign_exc high for 1 cycle; without the macro: next fetch at 0x100.
REQ-042 Start with pc=0xFFFF_FFFC and ack -> pc_out=0x0; then assert reset during DRAIN -> all outputs match REQ-031 the next cycle.
